// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
//
// Instruction memory read bus between the fetch stage and instruction memory.
// It is a single-outstanding request/acknowledge read channel.
//
// Signal names are seen from the fetch stage, which is the bus master:
//   o_IMEM_REQ    master -> slave  read request, held until acknowledged
//   o_IMEM_ADDR   master -> slave  read address, stable while o_IMEM_REQ is high
//   i_IMEM_ACK    slave  -> master acknowledge; RDATA/ERR are valid with it
//   i_IMEM_RDATA  slave  -> master read data
//   i_IMEM_ERR    slave  -> master bus error qualifier
//
// Modports:
//   master : used by fetch_unit
//   slave  : used by the instruction memory or a bench model
// ----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        o_IMEM_REQ;
    logic [31:0] o_IMEM_ADDR;
    logic        i_IMEM_ACK;
    logic [31:0] i_IMEM_RDATA;
    logic        i_IMEM_ERR;

    modport master (
        output o_IMEM_REQ,
        output o_IMEM_ADDR,
        input  i_IMEM_ACK,
        input  i_IMEM_RDATA,
        input  i_IMEM_ERR
    );

    modport slave (
        input  o_IMEM_REQ,
        input  o_IMEM_ADDR,
        output i_IMEM_ACK,
        output i_IMEM_RDATA,
        output i_IMEM_ERR
    );
endinterface : fetch_unit_if

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. It takes the program counter published by decode
// and runs one request/acknowledge read at a time on the instruction memory
// bus. It presents the fetched word with a valid flag until decode consumes
// it with i_EN. A redirect, meaning i_PC moved away from the in-flight or held
// address, discards stale data. A bus error or a timeout yields NOOP_INSN with
// o_FETCH_FAULT set.
//
// Parameters:
//   TIMEOUT_CYCLES  unacknowledged BUSY cycles before a fetch is abandoned
//                   (1..255)
//   NOOP_INSN       word presented in place of a faulted fetch
//
// Build option:
//   FETCH_MISALIGN_EN  when defined, a PC with i_PC[1:0] != 0 is not fetched.
//                      It produces a faulted NOOP one cycle after sampling.
//                      When undefined, the PC is word-aligned by dropping
//                      bits [1:0], and all PC comparisons ignore those bits.
//
// Ports:
//   i_CLK                clock, rising edge
//   i_RST                synchronous active-high reset
//   i_PC                 fetch address from decode
//   i_EN                 decode enable; i_EN & o_INSTRUCTION_VALID consumes
//   o_INSTRUCTION        fetched (or substituted) word
//   o_INSTRUCTION_VALID  word is valid for the current i_PC
//   o_FETCH_FAULT        presented word is a substituted NOOP
//   imem                 instruction memory bus (master side)
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOOP_INSN      = 32'h0000_0013
) (
    input  logic         i_CLK,
    input  logic         i_RST,
    input  logic [31:0]  i_PC,
    input  logic         i_EN,
    output logic [31:0]  o_INSTRUCTION,
    output logic         o_INSTRUCTION_VALID,
    output logic         o_FETCH_FAULT,
    fetch_unit_if.master imem
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_HOLD
    } state_t;

    // Value of tcnt_q on the last cycle the request may stay unacknowledged.
    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [31:0] tag_q;     // address of the in-flight or held fetch
    logic [7:0]  tcnt_q;    // unacknowledged BUSY cycles so far
    logic        req_q;
    logic [31:0] addr_q;
    logic [31:0] insn_q;
    logic        valid_q;
    logic        fault_q;

    logic [31:0] fetch_addr_d;   // tag to capture when leaving IDLE
    logic        pc_misaligned;  // IDLE should fault instead of issuing a read
    logic        pc_match;       // i_PC still refers to tag_q

`ifdef FETCH_MISALIGN_EN
    assign fetch_addr_d  = i_PC;
    assign pc_misaligned = (i_PC[1:0] != 2'b00);
    assign pc_match      = (i_PC == tag_q);
`else
    // Only word addresses exist in this build, so the low PC bits are
    // dropped on the way in and ignored when checking for a redirect.
    assign fetch_addr_d  = {i_PC[31:2], 2'b00};
    assign pc_misaligned = 1'b0;
    assign pc_match      = (i_PC[31:2] == tag_q[31:2]);

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_PC[1:0], tag_q[1:0]};
`endif

    // Control FSM. Every output is a register, so decode and the bus see
    // glitch-free values that change only at clock edges.
    // NOTE: state is assigned with <= so every register updates from values
    // sampled before the edge. With = the order of statements would change
    // the result and simulation would disagree with synthesis.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= S_IDLE;
            tag_q   <= '0;
            tcnt_q  <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            insn_q  <= NOOP_INSN;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                // Sample the PC every idle cycle and start a fetch for it.
                S_IDLE: begin
                    tag_q  <= fetch_addr_d;
                    tcnt_q <= '0;
                    if (pc_misaligned) begin
                        // No bus traffic. Present the fault next cycle.
                        insn_q  <= NOOP_INSN;
                        fault_q <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end else begin
                        req_q   <= 1'b1;
                        addr_q  <= fetch_addr_d;
                        state_q <= S_BUSY;
                    end
                end

                // The request stays up until acknowledged or timed out. A
                // redirect while waiting does not cancel the request: the
                // transaction completes and its data is dropped. The ack is
                // tested first, so an ack on the last allowed cycle still wins
                // over the timeout.
                S_BUSY: begin
                    if (imem.i_IMEM_ACK) begin
                        req_q <= 1'b0;
                        if (pc_match) begin
                            insn_q  <= imem.i_IMEM_ERR ? NOOP_INSN
                                                       : imem.i_IMEM_RDATA;
                            fault_q <= imem.i_IMEM_ERR;
                            valid_q <= 1'b1;
                            state_q <= S_HOLD;
                        end else begin
                            // Redirect won the race with the data.
                            state_q <= S_IDLE;
                        end
                    end else if (tcnt_q == TCNT_LAST) begin
                        req_q   <= 1'b0;
                        insn_q  <= NOOP_INSN;
                        fault_q <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end else begin
                        tcnt_q <= tcnt_q + 8'd1;
                    end
                end

                // Hold the word until decode takes it or moves away from it.
                // Consume together with a PC change counts as a consume.
                S_HOLD: begin
                    if (i_EN || !pc_match) begin
                        valid_q <= 1'b0;
                        fault_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_INSTRUCTION       = insn_q;
    assign o_INSTRUCTION_VALID = valid_q;
    assign o_FETCH_FAULT       = fault_q;
    assign imem.o_IMEM_REQ     = req_q;
    assign imem.o_IMEM_ADDR    = addr_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit, built with TIMEOUT_CYCLES=4. A table of
// per-cycle {inputs, expected outputs} records covers the basic fetch, bus
// error, stall, redirect and consume cases. Hand-written sequences cover wait
// states with a redirect, timeout, a five-cycle stall, misalignment and reset
// during a fetch.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] NOOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        en;
    logic [31:0] insn;
    logic        valid;
    logic        fault;

    int n_total = 0;
    int n_pass  = 0;

    fetch_unit_if imem_bus ();

    fetch_unit #(
        .TIMEOUT_CYCLES (4),
        .NOOP_INSN      (NOOP)
    ) dut (
        .i_CLK               (clk),
        .i_RST               (rst),
        .i_PC                (pc),
        .i_EN                (en),
        .o_INSTRUCTION       (insn),
        .o_INSTRUCTION_VALID (valid),
        .o_FETCH_FAULT       (fault),
        .imem                (imem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        en;
        logic        ack;
        logic        err;
        logic [31:0] rdata;
        logic        x_req;
        logic [31:0] x_addr;   // compared only when x_req
        logic        x_valid;
        logic [31:0] x_insn;   // compared only when x_valid
        logic        x_fault;  // compared only when x_valid
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [31:0] p, input logic e, input logic a,
                                input logic r, input logic [31:0] d,
                                input logic xr, input logic [31:0] xa,
                                input logic xv, input logic [31:0] xi,
                                input logic xf);
        vec_t v;
        v.pc = p; v.en = e; v.ack = a; v.err = r; v.rdata = d;
        v.x_req = xr; v.x_addr = xa; v.x_valid = xv; v.x_insn = xi; v.x_fault = xf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input logic [31:0] p, input logic e, input logic a,
                         input logic r, input logic [31:0] d);
        pc = p; en = e;
        imem_bus.i_IMEM_ACK = a; imem_bus.i_IMEM_ERR = r; imem_bus.i_IMEM_RDATA = d;
    endtask

    // Advance one edge, then sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  req_cycles;
        bit  saw_valid;

        // pc, en, ack, err, rdata | req, addr, valid, insn, fault
        vecs[0]  = mk(32'h0, 0, 0, 0, 32'h0,        1, 32'h0,  0, 32'h0,        0);
        vecs[1]  = mk(32'h0, 0, 1, 0, 32'h00500093, 0, 32'h0,  1, 32'h00500093, 0);
        vecs[2]  = mk(32'h0, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,        0);
        vecs[3]  = mk(32'h4, 0, 0, 0, 32'h0,        1, 32'h4,  0, 32'h0,        0);
        vecs[4]  = mk(32'h4, 0, 1, 1, 32'hdeadbeef, 0, 32'h0,  1, NOOP,         1);
        vecs[5]  = mk(32'h4, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,        0);
        vecs[6]  = mk(32'h8, 0, 0, 0, 32'h0,        1, 32'h8,  0, 32'h0,        0);
        vecs[7]  = mk(32'h8, 0, 1, 0, 32'h00a00113, 0, 32'h0,  1, 32'h00a00113, 0);
        vecs[8]  = mk(32'h8, 0, 0, 0, 32'h0,        0, 32'h0,  1, 32'h00a00113, 0);
        vecs[9]  = mk(32'hc, 0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,        0);
        vecs[10] = mk(32'hc, 0, 0, 0, 32'h0,        1, 32'hc,  0, 32'h0,        0);
        vecs[11] = mk(32'h10, 0, 1, 0, 32'h0badf00d, 0, 32'h0, 0, 32'h0,        0);
        vecs[12] = mk(32'h10, 0, 0, 0, 32'h0,       1, 32'h10, 0, 32'h0,        0);
        vecs[13] = mk(32'h10, 0, 1, 0, 32'h11111111, 0, 32'h0, 1, 32'h11111111, 0);
        vecs[14] = mk(32'h14, 1, 0, 0, 32'h0,       0, 32'h0,  0, 32'h0,        0);

        // ---------------- reset state ----------------
        rst = 1'b1;
        drive(32'h0, 0, 0, 0, 32'h0);
        step();
        step();
        check("rst req",   {31'b0, imem_bus.o_IMEM_REQ}, 32'd0);
        check("rst addr",  imem_bus.o_IMEM_ADDR, 32'h0);
        check("rst valid", {31'b0, valid}, 32'd0);
        check("rst fault", {31'b0, fault}, 32'd0);
        check("rst insn",  insn, NOOP);
        rst = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].pc, vecs[i].en, vecs[i].ack, vecs[i].err, vecs[i].rdata);
            step();
            check($sformatf("vec%0d req", i), {31'b0, imem_bus.o_IMEM_REQ}, {31'b0, vecs[i].x_req});
            if (vecs[i].x_req)
                check($sformatf("vec%0d addr", i), imem_bus.o_IMEM_ADDR, vecs[i].x_addr);
            check($sformatf("vec%0d valid", i), {31'b0, valid}, {31'b0, vecs[i].x_valid});
            if (vecs[i].x_valid) begin
                check($sformatf("vec%0d insn", i), insn, vecs[i].x_insn);
                check($sformatf("vec%0d fault", i), {31'b0, fault}, {31'b0, vecs[i].x_fault});
            end
        end

        // ---------------- wait states plus redirect ----------------
        drive(32'h100, 0, 0, 0, 32'h0);
        step();                                   // BUSY, tcnt 0
        check("wr req0",  {31'b0, imem_bus.o_IMEM_REQ}, 32'd1);
        check("wr addr0", imem_bus.o_IMEM_ADDR, 32'h100);
        step();                                   // wait 1
        drive(32'h200, 0, 0, 0, 32'h0);
        step();                                   // wait 2, PC redirected
        check("wr addr held", imem_bus.o_IMEM_ADDR, 32'h100);
        check("wr req held",  {31'b0, imem_bus.o_IMEM_REQ}, 32'd1);
        step();                                   // wait 3
        check("wr valid wait", {31'b0, valid}, 32'd0);
        drive(32'h200, 0, 1, 0, 32'haaaa0100);    // late ack for 0x100
        step();
        check("wr discard valid", {31'b0, valid}, 32'd0);
        check("wr discard req",   {31'b0, imem_bus.o_IMEM_REQ}, 32'd0);
        drive(32'h200, 0, 0, 0, 32'h0);
        step();
        check("wr req new",  {31'b0, imem_bus.o_IMEM_REQ}, 32'd1);
        check("wr addr new", imem_bus.o_IMEM_ADDR, 32'h200);
        drive(32'h200, 0, 1, 0, 32'hbbbb0200);
        step();
        check("wr valid new", {31'b0, valid}, 32'd1);
        check("wr insn new",  insn, 32'hbbbb0200);
        drive(32'h200, 1, 0, 0, 32'h0);
        step();                                   // consumed -> IDLE

        // ---------------- timeout ----------------
        drive(32'h300, 0, 0, 0, 32'h0);
        step();
        req_cycles = 0;
        saw_valid  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_bus.o_IMEM_REQ) req_cycles++;
            if (valid) begin
                saw_valid = 1'b1;
                break;
            end
            step();
        end
        check("to saw valid",  {31'b0, saw_valid}, 32'd1);
        check("to req cycles", req_cycles, 32'd4);
        check("to insn",       insn, NOOP);
        check("to fault",      {31'b0, fault}, 32'd1);
        drive(32'h300, 0, 1, 0, 32'hcccccccc);    // stray ack while holding
        step();
        check("to stray valid", {31'b0, valid}, 32'd1);
        check("to stray insn",  insn, NOOP);
        check("to stray req",   {31'b0, imem_bus.o_IMEM_REQ}, 32'd0);
        drive(32'h300, 1, 0, 0, 32'h0);
        step();

        // ---------------- five-cycle stall ----------------
        drive(32'h400, 0, 0, 0, 32'h0);
        step();
        drive(32'h400, 0, 1, 0, 32'h12345678);
        step();
        drive(32'h400, 0, 0, 0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stall%0d valid", i), {31'b0, valid}, 32'd1);
            check($sformatf("stall%0d insn", i),  insn, 32'h12345678);
            check($sformatf("stall%0d req", i),   {31'b0, imem_bus.o_IMEM_REQ}, 32'd0);
        end
        drive(32'h404, 0, 0, 0, 32'h0);           // PC change while holding
        step();
        check("stall redirect valid", {31'b0, valid}, 32'd0);

        // ---------------- misalignment ----------------
        drive(32'h102, 0, 0, 0, 32'h0);
        step();
`ifdef FETCH_MISALIGN_EN
        check("mis req",   {31'b0, imem_bus.o_IMEM_REQ}, 32'd0);
        check("mis valid", {31'b0, valid}, 32'd1);
        check("mis insn",  insn, NOOP);
        check("mis fault", {31'b0, fault}, 32'd1);
`else
        check("mis req",  {31'b0, imem_bus.o_IMEM_REQ}, 32'd1);
        check("mis addr", imem_bus.o_IMEM_ADDR, 32'h100);
        drive(32'h102, 0, 1, 0, 32'h02000093);
        step();
        check("mis valid", {31'b0, valid}, 32'd1);
        check("mis insn",  insn, 32'h02000093);
        check("mis fault", {31'b0, fault}, 32'd0);
`endif
        drive(32'h102, 1, 0, 0, 32'h0);
        step();

        // ---------------- reset mid-fetch ----------------
        drive(32'h500, 0, 0, 0, 32'h0);
        step();
        check("rm req busy", {31'b0, imem_bus.o_IMEM_REQ}, 32'd1);
        rst = 1'b1;
        step();
        check("rm req dropped", {31'b0, imem_bus.o_IMEM_REQ}, 32'd0);
        check("rm addr",        imem_bus.o_IMEM_ADDR, 32'h0);
        rst = 1'b0;
        drive(32'h500, 0, 1, 0, 32'hdddddddd);    // late ack arrives in IDLE
        step();
        check("rm late ack valid", {31'b0, valid}, 32'd0);
        check("rm refetch req",    {31'b0, imem_bus.o_IMEM_REQ}, 32'd1);
        drive(32'h500, 0, 1, 0, 32'h00100073);
        step();
        check("rm refetch valid", {31'b0, valid}, 32'd1);
        check("rm refetch insn",  insn, 32'h00100073);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fetch_unit
